// File: rtl/rps_match_scorer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rps_pkg
//  Description : Shared result codes, match state encoding and display glyph
//                indices for the rock-paper-scissors match scorer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rps_pkg;

  // Round outcome as delivered by the round core
  typedef enum logic [1:0] {
    RES_TIE = 2'b00,
    RES_P1  = 2'b01,
    RES_P2  = 2'b10,
    RES_INV = 2'b11
  } result_e;

  // Match progress
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_e;

  // Glyph index fed to the 7-segment decoder
  typedef logic [2:0] glyph_t;

  localparam glyph_t GLY_0     = 3'd0;
  localparam glyph_t GLY_1     = 3'd1;
  localparam glyph_t GLY_2     = 3'd2;
  localparam glyph_t GLY_DASH  = 3'd3;
  localparam glyph_t GLY_BLANK = 3'd4;

  // A round outcome displays as the digit of the player it favours ('0' for a tie)
  function automatic glyph_t result_glyph(input result_e r);
    glyph_t g;
    case (r)
      RES_P1:  g = GLY_1;
      RES_P2:  g = GLY_2;
      RES_TIE: g = GLY_0;
      default: g = GLY_DASH;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rps_match_scorer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rps_match_scorer_if
//  Description : Round-result input and score/display output bundle of the
//                match scorer. master = round source/observer, slave = scorer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rps_match_scorer_if #(
  parameter int SCORE_W = 4,
  parameter int ROUND_W = 4
);

  logic               round_valid;
  logic [1:0]         round_result;
  logic               new_match;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [ROUND_W-1:0] rounds_played;
  logic [3:0]         invalid_cnt;
  logic               match_over;
  logic [1:0]         match_winner;
  logic [6:0]         seg;

  modport master (
    output round_valid, round_result, new_match,
    input  p1_score, p2_score, rounds_played, invalid_cnt,
           match_over, match_winner, seg
  );

  modport slave (
    input  round_valid, round_result, new_match,
    output p1_score, p2_score, rounds_played, invalid_cnt,
           match_over, match_winner, seg
  );

endinterface
`default_nettype wire

// File: rtl/rps_match_scorer_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Glyph index to active-high {g,f,e,d,c,b,a} segment pattern.
//                Purely combinational; the caller registers the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import rps_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg
);

  // Lookup of the five glyphs; unused indices show blank
  always_comb begin
    seg = 7'b0000000;
    case (glyph)
      GLY_0:    seg = 7'b0111111;
      GLY_1:    seg = 7'b0000110;
      GLY_2:    seg = 7'b1011011;
      GLY_DASH: seg = 7'b1000000;
      default:  seg = 7'b0000000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rps_match_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : rps_match_scorer
//  Description : Accumulates per-player round wins, runs a first-to-WIN_SCORE
//                match FSM and drives the registered 7-segment result display.
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_SCORE = 3,
  parameter int SCORE_W   = 4,
  parameter int ROUND_W   = 4,
  parameter int BLINK_DIV = 22
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rps_match_scorer_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

  state_e               state_q,   state_d;
  logic [SCORE_W-1:0]   p1_q,      p1_d;
  logic [SCORE_W-1:0]   p2_q,      p2_d;
  logic [ROUND_W-1:0]   rounds_q,  rounds_d;
  logic [3:0]           inv_q,     inv_d;
  logic                 over_q,    over_d;
  logic [1:0]           winner_q,  winner_d;
  result_e              last_q,    last_d;
  logic [BLINK_DIV:0]   blink_q,   blink_d;
  logic [6:0]           seg_q,     seg_d;

  logic [SCORE_W-1:0]   p1_inc;
  logic [SCORE_W-1:0]   p2_inc;
  glyph_t               glyph_sel;

  assign p1_inc = p1_q + 1'b1;
  assign p2_inc = p2_q + 1'b1;

  // Next-state and counter update; new_match overrides any round in the same cycle
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    rounds_d = rounds_q;
    inv_d    = inv_q;
    over_d   = over_q;
    winner_d = winner_q;
    last_d   = last_q;
    blink_d  = blink_q;

    if (bus.new_match) begin
      state_d  = IDLE;
      p1_d     = '0;
      p2_d     = '0;
      rounds_d = '0;
      inv_d    = '0;
      over_d   = 1'b0;
      winner_d = 2'b00;
      blink_d  = '0;
    end else if (state_q == OVER) begin
      // Rounds are ignored once decided; only the blink timer runs
      blink_d = blink_q + 1'b1;
    end else if (bus.round_valid) begin
      if (result_e'(bus.round_result) == RES_INV) begin
        if (inv_q != 4'hF) inv_d = inv_q + 1'b1;
      end else begin
        if (rounds_q != {ROUND_W{1'b1}}) rounds_d = rounds_q + 1'b1;
        last_d  = result_e'(bus.round_result);
        state_d = PLAY;
        if (result_e'(bus.round_result) == RES_P1) begin
          p1_d = p1_inc;
          if (p1_inc == WIN_Q) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = 2'b01;
            blink_d  = '0;
          end
        end else if (result_e'(bus.round_result) == RES_P2) begin
          p2_d = p2_inc;
          if (p2_inc == WIN_Q) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = 2'b10;
            blink_d  = '0;
          end
        end
      end
    end
  end

  // Display glyph follows the post-update state so seg lines up with the counters
  always_comb begin
    glyph_sel = GLY_DASH;
    case (state_d)
      IDLE:    glyph_sel = GLY_DASH;
      PLAY:    glyph_sel = result_glyph(last_d);
      OVER:    glyph_sel = blink_d[BLINK_DIV] ? GLY_BLANK
                         : ((winner_d == 2'b10) ? GLY_2 : GLY_1);
      default: glyph_sel = GLY_DASH;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .glyph (glyph_sel),
    .seg   (seg_d)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      rounds_q <= '0;
      inv_q    <= '0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
      last_q   <= RES_TIE;
      blink_q  <= '0;
      seg_q    <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      rounds_q <= rounds_d;
      inv_q    <= inv_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      blink_q  <= blink_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.p1_score      = p1_q;
  assign bus.p2_score      = p2_q;
  assign bus.rounds_played = rounds_q;
  assign bus.invalid_cnt   = inv_q;
  assign bus.match_over    = over_q;
  assign bus.match_winner  = winner_q;
  assign bus.seg           = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rps_match_scorer
//  Description : Self-checking bench for rps_match_scorer (WIN_SCORE=3,
//                BLINK_DIV=2): directed scenarios plus random rounds against
//                a score-keeping reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rps_match_scorer;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rps_match_scorer_if #(.SCORE_W(4), .ROUND_W(4)) bus ();

  rps_match_scorer #(
    .WIN_SCORE (3),
    .SCORE_W   (4),
    .ROUND_W   (4),
    .BLINK_DIV (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: match outcome kept as plain integers
  int m_p1, m_p2, m_rounds, m_inv, m_winner, m_last, m_phase, m_ocyc;

  function automatic logic [6:0] digit_seg(input int d);
    if (d == 1) return SEG_1;
    if (d == 2) return SEG_2;
    return SEG_0;
  endfunction

  function automatic logic [6:0] model_seg();
    if (m_phase == 0) return SEG_DASH;
    if (m_phase == 1) return digit_seg(m_last);
    return (((m_ocyc / 4) % 2) == 0) ? digit_seg(m_winner) : SEG_BLANK;
  endfunction

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0;
    m_winner = 0; m_phase = 0; m_ocyc = 0;
  endtask

  task automatic model_step(input bit rv, input int res, input bit nm);
    if (nm) begin
      model_clear();
    end else if (m_phase == 2) begin
      m_ocyc++;
    end else if (rv) begin
      if (res == 3) begin
        m_inv = (m_inv < 15) ? m_inv + 1 : 15;
      end else begin
        m_rounds = (m_rounds < 15) ? m_rounds + 1 : 15;
        m_last   = res;
        m_phase  = 1;
        if (res == 1) m_p1++;
        if (res == 2) m_p2++;
        if (m_p1 == 3) begin m_phase = 2; m_winner = 1; m_ocyc = 0; end
        if (m_p2 == 3) begin m_phase = 2; m_winner = 2; m_ocyc = 0; end
      end
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge
  task automatic step(input bit rv, input logic [1:0] res, input bit nm);
    bus.round_valid  = rv;
    bus.round_result = res;
    bus.new_match    = nm;
    @(posedge clk);
    #1;
    bus.round_valid = 1'b0;
    bus.new_match   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.p1_score, bus.p2_score, bus.rounds_played, bus.invalid_cnt} !== 16'h0) begin
      bad++;
      $display("FAIL reset_counters got=%h want=0000",
               {bus.p1_score, bus.p2_score, bus.rounds_played, bus.invalid_cnt});
    end
    total++;
    if ({bus.match_over, bus.match_winner} !== 3'b000) begin
      bad++;
      $display("FAIL reset_match got=%b want=000", {bus.match_over, bus.match_winner});
    end
    total++;
    if (bus.seg !== SEG_DASH) begin
      bad++;
      $display("FAIL reset_seg got=%b want=%b", bus.seg, SEG_DASH);
    end
  endtask

  task automatic test_match_p1();
    step(1, 2'b01, 0);
    total++;
    if (bus.p1_score !== 4'd1 || bus.seg !== SEG_1 || bus.match_over !== 1'b0) begin
      bad++;
      $display("FAIL p1_first got p1=%0d seg=%b over=%b want 1/%b/0",
               bus.p1_score, bus.seg, bus.match_over, SEG_1);
    end
    step(0, 2'b00, 0);
    step(1, 2'b00, 0);
    total++;
    if (bus.seg !== SEG_0 || bus.rounds_played !== 4'd2 || bus.p1_score !== 4'd1) begin
      bad++;
      $display("FAIL tie_round got seg=%b rounds=%0d p1=%0d want %b/2/1",
               bus.seg, bus.rounds_played, bus.p1_score, SEG_0);
    end
    step(1, 2'b01, 0);
    step(1, 2'b01, 0);
    total++;
    if ({bus.p1_score, bus.p2_score, bus.rounds_played} !== {4'd3, 4'd0, 4'd4}) begin
      bad++;
      $display("FAIL p1_win_counts got p1=%0d p2=%0d rounds=%0d want 3/0/4",
               bus.p1_score, bus.p2_score, bus.rounds_played);
    end
    total++;
    if ({bus.match_over, bus.match_winner} !== 3'b101 || bus.seg !== SEG_1) begin
      bad++;
      $display("FAIL p1_win_flags got over=%b winner=%b seg=%b want 1/01/%b",
               bus.match_over, bus.match_winner, bus.seg, SEG_1);
    end
  endtask

  task automatic test_over_ignore();
    step(1, 2'b10, 0);
    step(1, 2'b11, 0);
    total++;
    if (bus.p2_score !== 4'd0 || bus.rounds_played !== 4'd4 || bus.invalid_cnt !== 4'd0) begin
      bad++;
      $display("FAIL over_ignore got p2=%0d rounds=%0d inv=%0d want 0/4/0",
               bus.p2_score, bus.rounds_played, bus.invalid_cnt);
    end
    total++;
    if ({bus.match_over, bus.match_winner} !== 3'b101) begin
      bad++;
      $display("FAIL over_hold got %b want 101", {bus.match_over, bus.match_winner});
    end
  endtask

  task automatic test_blink();
    logic [6:0] want;
    step(0, 2'b00, 1);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    for (int k = 0; k < 18; k++) begin
      want = (((k / 4) % 2) == 0) ? SEG_2 : SEG_BLANK;
      total++;
      if (bus.seg !== want || bus.match_winner !== 2'b10) begin
        bad++;
        $display("FAIL blink_k%0d got seg=%b winner=%b want %b/10",
                 k, bus.seg, bus.match_winner, want);
      end
      step(0, 2'b00, 0);
    end
  endtask

  task automatic test_invalid();
    step(0, 2'b00, 1);
    step(1, 2'b11, 0);
    total++;
    if (bus.invalid_cnt !== 4'd1 || bus.rounds_played !== 4'd0 || bus.seg !== SEG_DASH
        || bus.match_over !== 1'b0) begin
      bad++;
      $display("FAIL invalid_one got inv=%0d rounds=%0d seg=%b over=%b want 1/0/%b/0",
               bus.invalid_cnt, bus.rounds_played, bus.seg, bus.match_over, SEG_DASH);
    end
    for (int i = 0; i < 16; i++) step(1, 2'b11, 0);
    total++;
    if (bus.invalid_cnt !== 4'd15 || bus.seg !== SEG_DASH) begin
      bad++;
      $display("FAIL invalid_sat got inv=%0d seg=%b want 15/%b",
               bus.invalid_cnt, bus.seg, SEG_DASH);
    end
  endtask

  task automatic test_collision();
    step(1, 2'b01, 0);
    step(1, 2'b10, 1);
    total++;
    if ({bus.p1_score, bus.p2_score, bus.rounds_played, bus.invalid_cnt} !== 16'h0
        || bus.seg !== SEG_DASH) begin
      bad++;
      $display("FAIL collision got p1=%0d p2=%0d rounds=%0d inv=%0d seg=%b want 0/0/0/0/%b",
               bus.p1_score, bus.p2_score, bus.rounds_played, bus.invalid_cnt,
               bus.seg, SEG_DASH);
    end
  endtask

  task automatic test_async_reset();
    step(1, 2'b10, 0);
    total++;
    if (bus.p2_score !== 4'd1) begin
      bad++;
      $display("FAIL async_pre got p2=%0d want 1", bus.p2_score);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.p2_score !== 4'd0 || bus.rounds_played !== 4'd0 || bus.seg !== SEG_DASH) begin
      bad++;
      $display("FAIL async_now got p2=%0d rounds=%0d seg=%b want 0/0/%b",
               bus.p2_score, bus.rounds_played, bus.seg, SEG_DASH);
    end
    // A round presented while reset is held must not be scored
    bus.round_valid  = 1'b1;
    bus.round_result = 2'b10;
    @(posedge clk);
    #1;
    bus.round_valid = 1'b0;
    rst = 1'b0;
    total++;
    if (bus.p2_score !== 4'd0 || bus.rounds_played !== 4'd0) begin
      bad++;
      $display("FAIL async_hold got p2=%0d rounds=%0d want 0/0",
               bus.p2_score, bus.rounds_played);
    end
  endtask

  task automatic test_random();
    bit         rv, nm;
    logic [1:0] res;
    do_reset();
    model_clear();
    m_last = 0;
    for (int c = 0; c < 400; c++) begin
      rv  = ($urandom_range(0, 3) != 0);
      res = 2'($urandom_range(0, 3));
      nm  = ($urandom_range(0, 29) == 0);
      step(rv, res, nm);
      model_step(rv, int'(res), nm);
      total++;
      if (bus.p1_score !== 4'(m_p1) || bus.p2_score !== 4'(m_p2)) begin
        bad++;
        $display("FAIL rand_scores c=%0d got %0d/%0d want %0d/%0d",
                 c, bus.p1_score, bus.p2_score, m_p1, m_p2);
      end
      total++;
      if (bus.rounds_played !== 4'(m_rounds) || bus.invalid_cnt !== 4'(m_inv)) begin
        bad++;
        $display("FAIL rand_counts c=%0d got rounds=%0d inv=%0d want %0d/%0d",
                 c, bus.rounds_played, bus.invalid_cnt, m_rounds, m_inv);
      end
      total++;
      if (bus.match_over !== (m_phase == 2) || bus.match_winner !== 2'(m_winner)) begin
        bad++;
        $display("FAIL rand_match c=%0d got over=%b winner=%b want %0d/%0d",
                 c, bus.match_over, bus.match_winner, m_phase == 2, m_winner);
      end
      total++;
      if (bus.seg !== model_seg()) begin
        bad++;
        $display("FAIL rand_seg c=%0d got %b want %b", c, bus.seg, model_seg());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.round_valid  = 1'b0;
    bus.round_result = 2'b00;
    bus.new_match    = 1'b0;
    #2;
    test_reset();
    test_match_p1();
    test_over_ignore();
    test_blink();
    test_invalid();
    test_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
